// File: rtl/knn_dist_sort.sv
// knn_dist_sort: L1-distance nearest/second-nearest search over 8 byte vectors, fully pipelined.
// Optional DIST_SORT_DIST_OUT_EN exposes the eight distances aligned with addr_1st/addr_2nd.
module knn_dist_sort #(
    parameter int PIPE_STAGES = 3,
    parameter int DIST_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           query,
    input  logic [63:0]           search_0,
    input  logic [63:0]           search_1,
    input  logic [63:0]           search_2,
    input  logic [63:0]           search_3,
    input  logic [63:0]           search_4,
    input  logic [63:0]           search_5,
    input  logic [63:0]           search_6,
    input  logic [63:0]           search_7,
    input  logic                  in_valid,
    output logic                  out_valid,
    output logic [2:0]            addr_1st,
    output logic [2:0]            addr_2nd
`ifdef DIST_SORT_DIST_OUT_EN
    ,
    output logic [8*DIST_W-1:0]   dist_out
`endif
);

    // Work is cut into NSTEP logical steps: abs-diff, three adder levels, three tournament levels.
    localparam int NSTEP = 7;
    localparam int NSEG  = PIPE_STAGES + 1;

    typedef logic [DIST_W-1:0] dist_t;

    // Larger than any reachable distance (max 2040), so it never wins a comparison.
    localparam dist_t SENTINEL = '1;

    typedef struct packed {
        dist_t [7:0][7:0] part;   // [vector][lane] partial sums; lane 0 ends up as d_i
        dist_t [7:0]      t1_d;
        logic  [7:0][2:0] t1_i;
        dist_t [7:0]      t2_d;
        logic  [7:0][2:0] t2_i;
    } work_t;

    // Halve the active lanes; lanes past the live range carry don't-care values.
    function automatic work_t add_level(input work_t w);
        work_t r;
        r = w;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                r.part[i][k] = w.part[i][2*k] + w.part[i][2*k+1];
            end
        end
        return r;
    endfunction

    // Merge neighbouring (min, second-min) pairs. The A side always holds lower indices,
    // so every tie resolves towards A.
    function automatic work_t tour_level(input work_t w, input logic from_dist);
        work_t       r;
        dist_t       a1d, a2d, b1d, b2d;
        logic [2:0]  a1i, a2i, b1i, b2i;
        r = w;
        for (int j = 0; j < 4; j++) begin
            if (from_dist) begin
                a1d = w.part[2*j][0];   a1i = 3'(2*j);
                a2d = SENTINEL;         a2i = 3'(2*j);
                b1d = w.part[2*j+1][0]; b1i = 3'(2*j+1);
                b2d = SENTINEL;         b2i = 3'(2*j+1);
            end else begin
                a1d = w.t1_d[2*j];      a1i = w.t1_i[2*j];
                a2d = w.t2_d[2*j];      a2i = w.t2_i[2*j];
                b1d = w.t1_d[2*j+1];    b1i = w.t1_i[2*j+1];
                b2d = w.t2_d[2*j+1];    b2i = w.t2_i[2*j+1];
            end
            if (b1d < a1d) begin
                r.t1_d[j] = b1d;
                r.t1_i[j] = b1i;
                r.t2_d[j] = (a1d <= b2d) ? a1d : b2d;
                r.t2_i[j] = (a1d <= b2d) ? a1i : b2i;
            end else begin
                r.t1_d[j] = a1d;
                r.t1_i[j] = a1i;
                r.t2_d[j] = (a2d <= b1d) ? a2d : b1d;
                r.t2_i[j] = (a2d <= b1d) ? a2i : b1i;
            end
        end
        return r;
    endfunction

    function automatic work_t apply_step(input int s, input work_t w);
        work_t r;
        case (s)
            1, 2, 3: r = add_level(w);
            4:       r = tour_level(w, 1'b1);
            5, 6:    r = tour_level(w, 1'b0);
            default: r = w;
        endcase
        return r;
    endfunction

    // Spreads the steps evenly over the NSEG combinational segments between registers.
    function automatic int seg_of(input int s);
        return (s * NSEG) / NSTEP;
    endfunction

    logic [7:0][63:0]     search_all;
    logic [63:0]          query_reg;
    logic [7:0][63:0]     search_reg;
    logic [PIPE_STAGES:0] vld_reg;
    work_t                absdiff_w;
    work_t                fin_w;

    assign search_all = {search_7, search_6, search_5, search_4,
                         search_3, search_2, search_1, search_0};

    // Data registers are free-running; only the valid chain needs reset.
    always_ff @(posedge clk) begin
        query_reg  <= query;
        search_reg <= search_all;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= {vld_reg[PIPE_STAGES-1:0], in_valid};
        end
    end

    always_comb begin
        absdiff_w = '0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
                absdiff_w.part[i][k] = DIST_W'(
                    (query_reg[8*k +: 8] > search_reg[i][8*k +: 8])
                        ? query_reg[8*k +: 8] - search_reg[i][8*k +: 8]
                        : search_reg[i][8*k +: 8] - query_reg[8*k +: 8]);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= PIPE_STAGES; gi++) begin : g_seg
            work_t seg_in_w;
            work_t seg_out_w;

            if (gi == 0) begin : g_first
                assign seg_in_w = absdiff_w;
            end else begin : g_pipe
                work_t pipe_reg;
                always_ff @(posedge clk) begin
                    pipe_reg <= g_seg[gi-1].seg_out_w;
                end
                assign seg_in_w = pipe_reg;
            end

            always_comb begin
                seg_out_w = seg_in_w;
                for (int s = 1; s < NSTEP; s++) begin
                    if (seg_of(s) == gi) begin
                        seg_out_w = apply_step(s, seg_out_w);
                    end
                end
            end
        end
    endgenerate

    assign fin_w = g_seg[PIPE_STAGES].seg_out_w;

    // Addresses (and distances) only move on a valid result so they hold through bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            addr_1st  <= 3'd0;
            addr_2nd  <= 3'd0;
`ifdef DIST_SORT_DIST_OUT_EN
            dist_out  <= '0;
`endif
        end else begin
            out_valid <= vld_reg[PIPE_STAGES];
            if (vld_reg[PIPE_STAGES]) begin
                addr_1st <= fin_w.t1_i[0];
                addr_2nd <= fin_w.t2_i[0];
`ifdef DIST_SORT_DIST_OUT_EN
                for (int i = 0; i < 8; i++) begin
                    dist_out[i*DIST_W +: DIST_W] <= fin_w.part[i][0];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_knn_dist_sort.sv
// Directed + streaming bench for knn_dist_sort: per-cycle output check against an L1 reference model.
module tb_knn_dist_sort;

    localparam int P   = 3;
    localparam int LAT = P + 2;
    localparam int DW  = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [63:0]       query = '0;
    logic [7:0][63:0]  srch = '0;
    logic              out_valid;
    logic [2:0]        addr_1st;
    logic [2:0]        addr_2nd;
`ifdef DIST_SORT_DIST_OUT_EN
    logic [8*DW-1:0]   dist_out;
`endif

    knn_dist_sort #(.PIPE_STAGES(P), .DIST_W(DW)) dut (
        .clk(clk), .rst(rst), .query(query),
        .search_0(srch[0]), .search_1(srch[1]), .search_2(srch[2]), .search_3(srch[3]),
        .search_4(srch[4]), .search_5(srch[5]), .search_6(srch[6]), .search_7(srch[7]),
        .in_valid(in_valid), .out_valid(out_valid),
        .addr_1st(addr_1st), .addr_2nd(addr_2nd)
`ifdef DIST_SORT_DIST_OUT_EN
        , .dist_out(dist_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                due;
        logic [2:0]        a1;
        logic [2:0]        a2;
        logic [7:0][10:0]  d;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errs = 0;
    int         checks = 0;
    int         n_emit = 0;
    int         n_exp = 0;
    logic [2:0] last_a1 = 3'd0;
    logic [2:0] last_a2 = 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void l1_model(input logic [63:0] qv, input logic [7:0][63:0] sv,
                                     output logic [7:0][10:0] d,
                                     output logic [2:0] a1, output logic [2:0] a2);
        int acc, x, y, best, sec;
        for (int i = 0; i < 8; i++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                x = int'(qv[8*k +: 8]);
                y = int'(sv[i][8*k +: 8]);
                acc += (x > y) ? x - y : y - x;
            end
            d[i] = 11'(acc);
        end
        best = 0;
        for (int i = 1; i < 8; i++) if (d[i] < d[best]) best = i;
        sec = (best == 0) ? 1 : 0;
        for (int i = 0; i < 8; i++) if (i != best && d[i] < d[sec]) sec = i;
        a1 = 3'(best);
        a2 = 3'(sec);
    endfunction

    // hand=1: addresses are the hand-computed constants; otherwise they come from the model.
    task automatic drive(input logic [63:0] qv, input logic [7:0][63:0] sv, input logic v,
                         input bit hand, input logic [2:0] h1, input logic [2:0] h2);
        exp_t       e;
        logic [2:0] m1, m2;
        @(negedge clk);
        rst      = 1'b1;
        query    = qv;
        srch     = sv;
        in_valid = v;
        if (v) begin
            l1_model(qv, sv, e.d, m1, m2);
            e.a1  = hand ? h1 : m1;
            e.a2  = hand ? h2 : m2;
            e.due = cyc + LAT;
            exp_q.push_back(e);
            n_exp++;
        end
    endtask

    task automatic reset_for(input int n);
        repeat (n) begin
            @(negedge clk);
            rst      = 1'b0;
            in_valid = 1'b1;
            n_exp   -= exp_q.size();
            exp_q.delete();
        end
    endtask

    task automatic bubbles(input int n);
        repeat (n) drive({$urandom, $urandom}, '0, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst && out_valid === 1'b1) n_emit++;
        if (!rst) begin
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_a1", 32'(addr_1st), 32'd0);
            check("rst_a2", 32'(addr_2nd), 32'd0);
            last_a1 = 3'd0;
            last_a2 = 3'd0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            check("valid", 32'(out_valid), 32'd1);
            check("addr_1st", 32'(addr_1st), 32'(mon_e.a1));
            check("addr_2nd", 32'(addr_2nd), 32'(mon_e.a2));
`ifdef DIST_SORT_DIST_OUT_EN
            for (int i = 0; i < 8; i++) check("dist", 32'(dist_out[i*DW +: DW]), 32'(mon_e.d[i]));
`endif
            last_a1 = mon_e.a1;
            last_a2 = mon_e.a2;
        end else begin
            check("bubble_valid", 32'(out_valid), 32'd0);
            check("hold_a1", 32'(addr_1st), 32'(last_a1));
            check("hold_a2", 32'(addr_2nd), 32'(last_a2));
        end
    end

    initial begin
        logic [7:0][63:0] sv;
        logic [63:0]      qv;
        int               src;

        query    = '1;
        srch     = '1;
        in_valid = 1'b1;
        reset_for(2);

        // d_i = 8*(7-i)
        for (int i = 0; i < 8; i++) sv[i] = 64'h0101010101010101 * 64'(7 - i);
        drive(64'h0, sv, 1'b1, 1'b1, 3'd7, 3'd6);
        // all equal
        for (int i = 0; i < 8; i++) sv[i] = 64'h1010101010101010;
        drive(64'h1010101010101010, sv, 1'b1, 1'b1, 3'd0, 3'd1);
        // only 3 and 5 match
        for (int i = 0; i < 8; i++) sv[i] = '1;
        sv[3] = 64'h1010101010101010;
        sv[5] = 64'h1010101010101010;
        drive(64'h1010101010101010, sv, 1'b1, 1'b1, 3'd3, 3'd5);
        // max distance and abs-diff direction
        for (int i = 0; i < 8; i++) sv[i] = '0;
        sv[4] = 64'hFEFEFEFEFEFEFEFE;
        sv[6] = 64'hFFFFFFFFFFFFFF00;
        drive('1, sv, 1'b1, 1'b1, 3'd4, 3'd6);
        // search above and below the query: d7=8, d5=16, others 1024
        for (int i = 0; i < 8; i++) sv[i] = '0;
        sv[5] = 64'h7E7E7E7E7E7E7E7E;
        sv[7] = 64'h8181818181818181;
        drive(64'h8080808080808080, sv, 1'b1, 1'b1, 3'd7, 3'd5);
        // d_i = 8*i
        for (int i = 0; i < 8; i++) sv[i] = 64'h0101010101010101 * 64'(i);
        drive(64'h0, sv, 1'b1, 1'b1, 3'd0, 3'd1);
        bubbles(2);

        for (int n = 0; n < 1000; n++) begin
            if (n == 500) bubbles(3);
            qv = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) begin
                sv[j] = {$urandom, $urandom};
                if (j > 0 && $urandom_range(0, 3) == 0) begin
                    src   = int'($urandom_range(0, j - 1));
                    sv[j] = sv[src];
                end
            end
            drive(qv, sv, 1'b1, 1'b0, 3'd0, 3'd0);
        end
        bubbles(8);

        // two results in flight when reset hits; neither may appear
        for (int i = 0; i < 8; i++) sv[i] = 64'h0101010101010101 * 64'(7 - i);
        drive(64'h0, sv, 1'b1, 1'b1, 3'd7, 3'd6);
        drive(64'h0, sv, 1'b1, 1'b1, 3'd7, 3'd6);
        reset_for(1);
        bubbles(8);
        sv[2] = '0;
        drive(64'h0, sv, 1'b1, 1'b1, 3'd2, 3'd7);
        bubbles(1);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        check("result_count", 32'(n_emit), 32'(n_exp));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
